bringup_status_mailbox: RTL and testbench

CPU-facing responder that owns the bring-up status register the simulation harness monitors for PASS/FAIL. Firmware writes progress, PASS or FAIL codes and heartbeat kicks over a simple single-cycle register bus; the block latches a final verdict, drives `status`, and forces a FAIL verdict when firmware stops making progress. Sits on the platform register bus next to the CPU and SCP RAMs; `status` feeds the top-level monitor.

---
 rtl/bringup_status_mailbox.sv | 173 +++++++++++++++++
 tb/tb_bringup_status_mailbox.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bringup_status_mailbox.sv
// Bring-up status mailbox: firmware reports progress/PASS/FAIL over a single-cycle register bus.
// Optional watchdog that forces FAIL on stalled firmware is compiled in with BRINGUP_WDT_EN.
module bringup_status_mailbox #(
    parameter logic [31:0] PASS_CODE      = 32'hA5A5A5A5,
    parameter logic [31:0] FAIL_CODE      = 32'hDEADBEEF,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic        done,
    output logic        pass,
    output logic        fail
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_e;

    localparam logic [1:0] REG_STATUS    = 2'd0;
    localparam logic [1:0] REG_HEARTBEAT = 2'd1;
    localparam logic [1:0] REG_CAUSE     = 2'd2;
    localparam logic [1:0] REG_CYCLES    = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_SW_PASS = 2'd1;
    localparam logic [1:0] CAUSE_SW_FAIL = 2'd2;
    localparam logic [1:0] CAUSE_WDT     = 2'd3;

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] status_q, status_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] cycles_q, cycles_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;

    logic        status_wr;
    logic        hb_wr;

    // Byte-lane bits of the address carry no meaning on this bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

`ifdef BRINGUP_WDT_EN
    localparam int unsigned     WDT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(TIMEOUT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_q, wdt_d;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        status_wr = req && we && (addr[3:2] == REG_STATUS);
        hb_wr     = req && we && (addr[3:2] == REG_HEARTBEAT);

        state_d  = state_q;
        status_d = status_q;
        cause_d  = cause_q;
        cycles_d = cycles_q;
        ack_d    = req;
        rdata_d  = '0;

        // Read data captures register values as they stand in the request cycle.
        if (req && !we) begin
            unique case (addr[3:2])
                REG_STATUS:    rdata_d = status_q;
                REG_HEARTBEAT: rdata_d = '0;
                REG_CAUSE:     rdata_d = {30'd0, cause_q};
                REG_CYCLES:    rdata_d = cycles_q;
                default:       rdata_d = '0;
            endcase
        end

        if (state_q == ST_RUN) begin
            if (status_wr) begin
                status_d = wdata;
                if (wdata == PASS_CODE) begin
                    state_d = ST_PASS;
                    cause_d = CAUSE_SW_PASS;
                end else if (wdata == FAIL_CODE) begin
                    state_d = ST_FAIL;
                    cause_d = CAUSE_SW_FAIL;
                end
            end
`ifdef BRINGUP_WDT_EN
            // A write in the expiry cycle wins over the timeout.
            else if (!hb_wr && (wdt_q == WDT_MAX)) begin
                state_d  = ST_FAIL;
                status_d = FAIL_CODE;
                cause_d  = CAUSE_WDT;
            end
`endif
            // The cycle that commits a verdict is not counted, so CYCLES matches the watchdog count.
            if ((state_d == ST_RUN) && (cycles_q != 32'hFFFF_FFFF)) begin
                cycles_d = cycles_q + 32'd1;
            end
        end

        done_d = (state_d != ST_RUN);
        pass_d = (state_d == ST_PASS);
        fail_d = (state_d == ST_FAIL);
    end

`ifdef BRINGUP_WDT_EN
    always_comb begin
        wdt_d = wdt_q;
        if (state_q == ST_RUN) begin
            if (status_wr || hb_wr) begin
                wdt_d = '0;
            end else if (state_d == ST_RUN) begin
                wdt_d = wdt_q + WDT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic unused_hb_wr;
    assign unused_hb_wr = hb_wr;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            status_q <= '0;
            cause_q  <= CAUSE_NONE;
            cycles_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign status = status_q;
    assign done   = done_q;
    assign pass   = pass_q;
    assign fail   = fail_q;

endmodule

// File: tb/tb_bringup_status_mailbox.sv
// Directed bench for bringup_status_mailbox; watchdog scenarios run only when BRINGUP_WDT_EN is defined.
module tb_bringup_status_mailbox;

    localparam logic [3:0] A_STATUS    = 4'h0;
    localparam logic [3:0] A_HEARTBEAT = 4'h4;
    localparam logic [3:0] A_CAUSE     = 4'h8;
    localparam logic [3:0] A_CYCLES    = 4'hC;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] status;
    logic        done;
    logic        pass;
    logic        fail;

    int checks_total;
    int checks_passed;

    bringup_status_mailbox #(
        .PASS_CODE     (32'hA5A5A5A5),
        .FAIL_CODE     (32'hDEADBEEF),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .status(status),
        .done  (done),
        .pass  (pass),
        .fail  (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // All tasks leave time at 1 ns after a rising edge, where outputs are sampled.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
        check("write_ack", 32'(ack), 32'd1);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        req  = 1'b1;
        we   = 1'b0;
        addr = a;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("read_ack", 32'(ack), 32'd1);
        d = rdata;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_b2b [4];

        checks_total  = 0;
        checks_passed = 0;

        // Reset values while reset is held.
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        #12;
        check("rst_ack",    32'(ack),  32'd0);
        check("rst_rdata",  rdata,     32'd0);
        check("rst_status", status,    32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_pass",   32'(pass), 32'd0);
        check("rst_fail",   32'(fail), 32'd0);

        // Progress code then PASS.
        do_reset();
        bus_read(A_CYCLES, rd);
        check("cycles_start", rd, 32'd0);
        bus_write(A_STATUS, 32'h0000_0010);
        check("progress_status", status, 32'h0000_0010);
        check("progress_done", 32'(done), 32'd0);
        bus_write(A_STATUS, 32'hA5A5A5A5);
        check("pass_status", status, 32'hA5A5A5A5);
        check("pass_pass", 32'(pass), 32'd1);
        check("pass_done", 32'(done), 32'd1);
        check("pass_fail", 32'(fail), 32'd0);
        bus_read(A_CAUSE, rd);
        check("pass_cause", rd, 32'd1);
        idle(1);
        check("ack_drops", 32'(ack), 32'd0);
        check("rdata_zero_idle", rdata, 32'd0);

        // Software FAIL is terminal; a later PASS write and a write to CAUSE are ignored.
        do_reset();
        bus_write(A_STATUS, 32'hDEADBEEF);
        check("fail_fail", 32'(fail), 32'd1);
        check("fail_done", 32'(done), 32'd1);
        bus_read(A_CAUSE, rd);
        check("fail_cause", rd, 32'd2);
        bus_write(A_STATUS, 32'hA5A5A5A5);
        check("terminal_status", status, 32'hDEADBEEF);
        check("terminal_pass", 32'(pass), 32'd0);
        bus_write(A_CAUSE, 32'h0000_0001);
        bus_read(A_CAUSE, rd);
        check("cause_ro", rd, 32'd2);
        idle(5);
        bus_read(A_CYCLES, rd);
        check("cycles_frozen", rd, 32'd0);
        bus_read(A_STATUS, rd);
        check("terminal_read", rd, 32'hDEADBEEF);

        // Back-to-back reads of all four registers; CYCLES counts edges 1..4 before the last read.
        do_reset();
        bus_write(A_STATUS, 32'h0000_1234);
        exp_b2b[0] = 32'h0000_1234;
        exp_b2b[1] = 32'd0;
        exp_b2b[2] = 32'd0;
        exp_b2b[3] = 32'd4;
        req = 1'b1;
        we  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = 4'(i * 4);
            @(posedge clk);
            #1;
            check($sformatf("b2b_ack%0d", i), 32'(ack), 32'd1);
            check($sformatf("b2b_rdata%0d", i), rdata, exp_b2b[i]);
        end
        req = 1'b0;
        idle(1);
        check("b2b_ack_end", 32'(ack), 32'd0);
        check("b2b_rdata_end", rdata, 32'd0);

        // Reset one cycle after the PASS write request; then a fresh PASS commits normally.
        do_reset();
        req = 1'b1; we = 1'b1; addr = A_STATUS; wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        check("pre_rst_pass", 32'(pass), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ack",    32'(ack),  32'd0);
        check("mid_rst_status", status,    32'd0);
        check("mid_rst_pass",   32'(pass), 32'd0);
        check("mid_rst_done",   32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_read(A_CAUSE, rd);
        check("mid_rst_cause", rd, 32'd0);
        bus_write(A_STATUS, 32'hA5A5A5A5);
        check("repass_pass", 32'(pass), 32'd1);
        bus_read(A_CAUSE, rd);
        check("repass_cause", rd, 32'd1);

`ifdef BRINGUP_WDT_EN
        // Watchdog expiry with no writes: FAIL after the 16th edge, CYCLES frozen at 15.
        do_reset();
        idle(15);
        check("wdt_not_yet", 32'(fail), 32'd0);
        idle(1);
        check("wdt_fail", 32'(fail), 32'd1);
        check("wdt_done", 32'(done), 32'd1);
        check("wdt_status", status, 32'hDEADBEEF);
        bus_read(A_CAUSE, rd);
        check("wdt_cause", rd, 32'd3);
        bus_read(A_CYCLES, rd);
        check("wdt_cycles", rd, 32'd15);

        // A write in the expiry cycle wins and restarts the window.
        do_reset();
        idle(15);
        bus_write(A_STATUS, 32'h0000_0077);
        check("race_fail", 32'(fail), 32'd0);
        check("race_status", status, 32'h0000_0077);
        idle(15);
        check("race_window_open", 32'(fail), 32'd0);
        idle(1);
        check("race_window_fail", 32'(fail), 32'd1);

        // Heartbeat every 10 cycles for 100 cycles, then stop kicking.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            bus_write(A_HEARTBEAT, 32'h0000_0000);
            idle(9);
        end
        check("hb_alive", 32'(done), 32'd0);
        idle(6);
        check("hb_last_window", 32'(fail), 32'd0);
        idle(1);
        check("hb_timeout_fail", 32'(fail), 32'd1);
        bus_read(A_CAUSE, rd);
        check("hb_timeout_cause", rd, 32'd3);
`else
        // Without the watchdog the block never leaves RUN on its own; HEARTBEAT writes are inert.
        do_reset();
        idle(40);
        check("nowdt_done", 32'(done), 32'd0);
        bus_write(A_HEARTBEAT, 32'h0000_FFFF);
        check("nowdt_hb_status", status, 32'd0);
        check("nowdt_hb_done", 32'(done), 32'd0);
        bus_read(A_CAUSE, rd);
        check("nowdt_cause", rd, 32'd0);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
